// File: rtl/vecaddsub_seq_if.sv
// Handshake bundle for vecaddsub_seq: operand vectors and mode in, result vector and overflow out.
// The master side drives operands and out_ready; the slave side is the arithmetic block.
interface vecaddsub_seq_if #(
  parameter int I = 20,
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [N-1:0] in1 [0:I-1];
  logic [N-1:0] in2 [0:I-1];
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out [0:I-1];
  logic         ovf;

  modport master (
    output in_valid, mode, in1, in2, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, mode, in1, in2, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/vecaddsub_seq.sv
// Sequential sign-magnitude vector add/subtract: P shared lane adders sweep the latched
// operands over ceil(I/P) cycles, saturating each element and flagging any saturation in ovf.
module vecaddsub_seq #(
  parameter int I = 20,
  parameter int Q = 15,
  parameter int N = 32,
  parameter int P = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  vecaddsub_seq_if.slave bus
);
  localparam int NCHUNK = (I + P - 1) / P;
  localparam int NPAD   = NCHUNK * P;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  // Q only describes the binary point; it must still lie inside the magnitude field.
  if (P < 1 || P > I || Q < 0 || Q > N - 1) begin : g_bad_params
    $error("vecaddsub_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic [N-1:0]       r_out [0:I-1];
  logic [N-1:0]       r_a   [0:I-1];
  logic [N-1:0]       r_b   [0:I-1];
  logic               r_mode;

  logic               w_accept;
  logic [N-1:0]       w_a_pad [0:NPAD-1];
  logic [N-1:0]       w_b_pad [0:NPAD-1];
  logic [N-1:0]       w_op_a  [0:P-1];
  logic [N-1:0]       w_op_b  [0:P-1];
  logic [N-1:0]       w_res   [0:P-1];
  logic [P-1:0]       w_lovf;

  // Sign-magnitude add (sub flips B's sign first). Returns {saturated, result}.
  function automatic logic [N:0] f_addsub_sat(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic sub);
    logic         sa, sb, s, ov;
    logic [N-1:0] ma, mb, wide;
    logic [N-2:0] m;
    sa = a[N-1];
    sb = b[N-1] ^ sub;
    ma = {1'b0, a[N-2:0]};
    mb = {1'b0, b[N-2:0]};
    ov = 1'b0;
    if (sa == sb) begin
      wide = ma + mb;
      s    = sa;
      if (wide[N-1]) begin
        m  = '1;
        ov = 1'b1;
      end else begin
        m  = wide[N-2:0];
      end
    end else if (ma >= mb) begin
      wide = ma - mb;
      m    = wide[N-2:0];
      s    = sa;
    end else begin
      wide = mb - ma;
      m    = wide[N-2:0];
      s    = sb;
    end
    // A zero magnitude is always reported as +0.
    if (m == '0) s = 1'b0;
    return {ov, s, m};
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  // Pad the operand store to a whole number of chunks so lanes past I see zeros.
  for (genvar k = 0; k < NPAD; k++) begin : g_pad
    if (k < I) begin : g_real
      assign w_a_pad[k] = r_a[k];
      assign w_b_pad[k] = r_b[k];
    end else begin : g_zero
      assign w_a_pad[k] = '0;
      assign w_b_pad[k] = '0;
    end
  end

  always_comb begin
    for (int l = 0; l < P; l++) begin
      w_op_a[l] = '0;
      w_op_b[l] = '0;
      for (int c = 0; c < NCHUNK; c++) begin
        if (IDX_W'(c) == r_idx) begin
          w_op_a[l] = w_a_pad[c * P + l];
          w_op_b[l] = w_b_pad[c * P + l];
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < P; l++) begin
      {w_lovf[l], w_res[l]} = f_addsub_sat(w_op_a[l], w_op_b[l], r_mode);
    end
  end

  // Operand capture: data only, loaded on the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a    <= bus.in1;
      r_b    <= bus.in2;
      r_mode <= bus.mode;
    end
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
      for (int j = 0; j < I; j++) r_out[j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_state    <= S_BUSY;
            r_in_ready <= 1'b0;
            r_ovf      <= 1'b0;
            r_idx      <= '0;
          end
        end
        S_BUSY: begin
          for (int j = 0; j < I; j++) begin
            if (IDX_W'(j / P) == r_idx) r_out[j] <= w_res[j % P];
          end
          r_ovf <= r_ovf | (|w_lovf);
          if (r_idx == LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf       = r_ovf;
  assign bus.out       = r_out;
endmodule

// File: tb/tb_vecaddsub_seq.sv
// Bench for vecaddsub_seq: table vectors, randomized vectors against a signed-integer model,
// handshake stall/remainder sequence on a small instance, and reset mid-operation.
module tb_vecaddsub_seq;
  localparam int N  = 32;
  localparam int I  = 20;
  localparam int P  = 4;
  localparam int I2 = 5;
  localparam int P2 = 2;
  localparam longint MAXM = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  always #5 clk = ~clk;

  vecaddsub_seq_if #(.I(I),  .N(N)) ifa ();
  vecaddsub_seq_if #(.I(I2), .N(N)) ifb ();

  vecaddsub_seq #(.I(I),  .Q(15), .N(N), .P(P))  dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  vecaddsub_seq #(.I(I2), .Q(15), .N(N), .P(P2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        eovf;
  } vec_t;

  vec_t tbl [9];

  // Reference: interpret as signed integers, do the arithmetic, clamp, re-encode.
  function automatic logic [32:0] ref_elem(input logic m, input logic [31:0] a, input logic [31:0] b);
    longint va, vb, r, mag;
    logic   ov;
    va = longint'(a[30:0]);
    if (a[31]) va = -va;
    vb = longint'(b[30:0]);
    if (b[31]) vb = -vb;
    r   = m ? (va - vb) : (va + vb);
    mag = (r < 0) ? -r : r;
    ov  = 1'b0;
    if (mag > MAXM) begin
      mag = MAXM;
      ov  = 1'b1;
    end
    return {ov, (r < 0), mag[30:0]};
  endfunction

  function automatic logic [31:0] rnd_elem();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return {s, 31'($urandom_range(0, 255))};
      2:       return {s, 31'h7FFF_FF00 | 31'($urandom_range(0, 255))};
      default: return {s, 31'h0};
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec_a(input string nm, input logic [31:0] e [I]);
    int bad;
    bad = -1;
    for (int j = 0; j < I; j++) if (ifa.out[j] !== e[j] && bad < 0) bad = j;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: out[%0d] got %h expected %h", nm, bad, ifa.out[bad], e[bad]);
    end
  endtask

  task automatic check_vec_b(input string nm, input logic [31:0] e [I2]);
    int bad;
    bad = -1;
    for (int j = 0; j < I2; j++) if (ifb.out[j] !== e[j] && bad < 0) bad = j;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: out[%0d] got %h expected %h", nm, bad, ifb.out[bad], e[bad]);
    end
  endtask

  task automatic start_a(input logic m, input logic [31:0] x [I], input logic [31:0] y [I]);
    @(negedge clk);
    check("a_in_ready_idle", ifa.in_ready, 1);
    ifa.mode     = m;
    ifa.in1      = x;
    ifa.in2      = y;
    ifa.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifa.mode     = ~m;
    for (int j = 0; j < I; j++) begin
      ifa.in1[j] = $urandom;
      ifa.in2[j] = $urandom;
    end
  endtask

  task automatic run_a(input string nm, input logic m, input logic [31:0] x [I],
                       input logic [31:0] y [I], input logic [31:0] e [I], input logic eovf);
    int lat;
    start_a(m, x, y);
    lat = 0;
    while (!ifa.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 5);
    check_vec_a({nm, "_out"}, e);
    check({nm, "_ovf"}, ifa.ovf, eovf);
    @(negedge clk);
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.out_ready = 1'b0;
    check({nm, "_valid_drop"}, ifa.out_valid, 0);
  endtask

  task automatic wait_b(input string nm);
    int lat;
    lat = 0;
    while (!ifb.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x [I];
    logic [31:0] y [I];
    logic [31:0] e [I];
    logic [31:0] xb [I2];
    logic [31:0] yb [I2];
    logic [31:0] x2 [I2];
    logic [31:0] y2 [I2];
    logic [31:0] eb [I2];
    logic [31:0] snap [I2];
    logic [32:0] r;
    logic        eovf, snap_ovf, stable;

    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{1'b1, 32'h0000_C000, 32'h0000_4000, 32'h0000_8000, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_8000, 32'h8000_8000, 32'h0000_0000, 1'b0};
    tbl[2] = '{1'b0, 32'h8000_2000, 32'h0000_6000, 32'h0000_4000, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_4000, 32'h8000_4000, 32'h0000_8000, 1'b0};
    tbl[4] = '{1'b1, 32'h8000_4000, 32'h0000_4000, 32'h8000_8000, 1'b0};
    tbl[5] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    tbl[6] = '{1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 32'h8000_0005, 32'h8000_0005, 32'h0000_0000, 1'b0};

    reset_n       = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b0;
    ifa.mode      = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b0;
    ifb.mode      = 1'b0;
    for (int j = 0; j < I; j++) begin
      ifa.in1[j] = '0;
      ifa.in2[j] = '0;
      e[j]       = '0;
    end
    for (int j = 0; j < I2; j++) begin
      ifb.in1[j] = '0;
      ifb.in2[j] = '0;
    end
    #12;
    check("rst_a_in_ready", ifa.in_ready, 1);
    check("rst_a_out_valid", ifa.out_valid, 0);
    check("rst_a_ovf", ifa.ovf, 0);
    check_vec_a("rst_a_out", e);
    check("rst_b_in_ready", ifb.in_ready, 1);
    check("rst_b_out_valid", ifb.out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < I; j++) begin
        x[j] = tbl[t].a;
        y[j] = tbl[t].b;
        e[j] = tbl[t].exp;
      end
      run_a($sformatf("tbl%0d", t), tbl[t].mode, x, y, e, tbl[t].eovf);
    end

    // Single saturating element, then a clean transaction must clear ovf.
    for (int j = 0; j < I; j++) begin
      x[j] = '0;
      y[j] = '0;
      e[j] = '0;
    end
    x[7] = 32'h7FFF_FFFF;
    y[7] = 32'h0000_0001;
    e[7] = 32'h7FFF_FFFF;
    run_a("sat_elem7", 1'b0, x, y, e, 1'b1);
    for (int j = 0; j < I; j++) begin
      x[j] = 32'h0000_C000;
      y[j] = 32'h0000_4000;
      e[j] = 32'h0000_8000;
    end
    run_a("after_sat", 1'b1, x, y, e, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic m;
      m    = 1'($urandom_range(0, 1));
      eovf = 1'b0;
      for (int j = 0; j < I; j++) begin
        x[j] = rnd_elem();
        y[j] = rnd_elem();
        r    = ref_elem(m, x[j], y[j]);
        e[j] = r[31:0];
        eovf = eovf | r[32];
      end
      run_a($sformatf("rnd%0d", t), m, x, y, e, eovf);
    end

    // Remainder instance: latency, long stall, ignored in_valid, new mode after handshake.
    for (int j = 0; j < I2; j++) begin
      xb[j] = rnd_elem();
      yb[j] = rnd_elem();
      x2[j] = rnd_elem();
      y2[j] = rnd_elem();
    end
    @(negedge clk);
    check("b_in_ready_idle", ifb.in_ready, 1);
    ifb.mode     = 1'b0;
    ifb.in1      = xb;
    ifb.in2      = yb;
    ifb.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    wait_b("b_first");
    eovf = 1'b0;
    for (int j = 0; j < I2; j++) begin
      r     = ref_elem(1'b0, xb[j], yb[j]);
      eb[j] = r[31:0];
      eovf  = eovf | r[32];
    end
    check_vec_b("b_first_out", eb);
    check("b_first_ovf", ifb.ovf, eovf);
    snap     = ifb.out;
    snap_ovf = ifb.ovf;
    stable   = 1'b1;
    @(negedge clk);
    ifb.mode     = 1'b1;
    ifb.in1      = x2;
    ifb.in2      = y2;
    ifb.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int j = 0; j < I2; j++) if (ifb.out[j] !== snap[j]) stable = 1'b0;
      if (ifb.ovf !== snap_ovf || ifb.in_ready !== 1'b0 || ifb.out_valid !== 1'b1) stable = 1'b0;
    end
    check("b_stall_stable", stable, 1);
    ifb.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifb.out_ready = 1'b0;
    check("b_hs_valid_drop", ifb.out_valid, 0);
    check("b_hs_in_ready", ifb.in_ready, 1);
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    wait_b("b_second");
    eovf = 1'b0;
    for (int j = 0; j < I2; j++) begin
      r     = ref_elem(1'b1, x2[j], y2[j]);
      eb[j] = r[31:0];
      eovf  = eovf | r[32];
    end
    check_vec_b("b_second_out", eb);
    check("b_second_ovf", ifb.ovf, eovf);
    @(negedge clk);
    ifb.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifb.out_ready = 1'b0;

    // Reset while chunk 2 is pending: partial results must vanish at once.
    for (int j = 0; j < I; j++) begin
      x[j] = 32'h0000_1000;
      y[j] = 32'h0000_0001;
    end
    start_a(1'b0, x, y);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_partial_written", ifa.out[0], 32'h0000_1001);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", ifa.out_valid, 0);
    check("mid_rst_in_ready", ifa.in_ready, 1);
    check("mid_rst_ovf", ifa.ovf, 0);
    for (int j = 0; j < I; j++) e[j] = '0;
    check_vec_a("mid_rst_out", e);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < I; j++) begin
      x[j] = 32'h0000_C000;
      y[j] = 32'h0000_4000;
      e[j] = 32'h0000_8000;
    end
    run_a("after_rst", 1'b1, x, y, e, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
